burst_slave_port: RTL

BURST_SLAVE_PORT -- requirements
Module: burst_slave_port

---
 rtl/burst_slave_port_pkg.sv | 27 ++
 rtl/burst_slave_port_serdes_shifter.sv | 32 +++
 rtl/burst_slave_port.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/burst_slave_port_pkg.sv
// rtl/burst_slave_port_pkg.sv - shared bus types and constants for the burst slave port
package burst_slave_port_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_LEN,
    ST_WDATA,
    ST_MWRITE,
    ST_SPLIT,
    ST_WAIT,
    ST_MREAD,
    ST_RDATA
  } state_t;

  localparam logic SMODE_READ  = 1'b0;
  localparam logic SMODE_WRITE = 1'b1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/burst_slave_port_serdes_shifter.sv
// rtl/burst_slave_port_serdes_shifter.sv - LANES-wide shift register, LSB-first in and out
module serdes_shifter #(
  parameter int WIDTH = 12,
  parameter int LANES = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic             shift,
  input  logic [LANES-1:0] din,
  input  logic [WIDTH-1:0] pdata,
  output logic [LANES-1:0] dout,
  output logic [WIDTH-1:0] shifted
);

  logic [WIDTH-1:0] sr;

  // New beats enter at the top so a completed field ends up top-aligned, first beat lowest.
  assign shifted = {din, sr[WIDTH-1:LANES]};
  assign dout    = sr[LANES-1:0];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sr <= '0;
    end else if (load) begin
      sr <= pdata;
    end else if (shift) begin
      sr <= shifted;
    end
  end

endmodule

// File: rtl/burst_slave_port.sv
// rtl/burst_slave_port.sv - serial burst slave: deserialises addr/len/data, drives a word memory port
module burst_slave_port
  import burst_slave_port_pkg::*;
#(
  parameter int ADDR_WIDTH    = 12,
  parameter int DATA_WIDTH    = 8,
  parameter int LANES         = 1,
  parameter int LEN_WIDTH     = 4,
  parameter int SPLIT_EN      = 0,
  parameter int SPLIT_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [LANES-1:0]      swdata,
  input  logic                  smode,
  input  logic                  mvalid,
  input  logic                  split_grant,
  output logic [LANES-1:0]      srdata,
  output logic                  svalid,
  output logic                  sready,
  output logic                  ssplit,
  output logic [ADDR_WIDTH-1:0] smemaddr,
  output logic [DATA_WIDTH-1:0] smemwdata,
  output logic                  smemwen,
  output logic                  smemren,
  input  logic [DATA_WIDTH-1:0] smemrdata,
  input  logic                  rvalid
);

  localparam int RX_W       = max3(ADDR_WIDTH, DATA_WIDTH, LEN_WIDTH);
  localparam int ADDR_BEATS = ADDR_WIDTH / LANES;
  localparam int LEN_BEATS  = LEN_WIDTH / LANES;
  localparam int DATA_BEATS = DATA_WIDTH / LANES;

  state_t                state, state_nxt;
  logic                  mode;
  logic [7:0]            beat_cnt;
  logic [7:0]            split_cnt;
  logic [LEN_WIDTH-1:0]  len, word_cnt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  rx_shift, tx_load, tx_shift, beat_last;
  logic [LANES-1:0]      sh_dout;
  logic [RX_W-1:0]       sh_next;

  // Receive and transmit never overlap within a burst, so one shifter serves both.
  serdes_shifter #(.WIDTH(RX_W), .LANES(LANES)) u_shifter (
    .clk     (clk),
    .rstn    (rstn),
    .load    (tx_load),
    .shift   (rx_shift || tx_shift),
    .din     (swdata),
    .pdata   (RX_W'(smemrdata)),
    .dout    (sh_dout),
    .shifted (sh_next)
  );

  always_ff @(posedge clk) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rx_shift  = 1'b0;
    tx_load   = 1'b0;
    tx_shift  = 1'b0;
    beat_last = 1'b0;
    sready    = 1'b0;
    ssplit    = 1'b0;
    smemwen   = 1'b0;
    smemren   = 1'b0;
    svalid    = 1'b0;
    srdata    = '0;
    case (state)
      ST_IDLE: begin
        sready = 1'b1;
        if (mvalid) begin
          rx_shift  = 1'b1;
          state_nxt = ST_ADDR;
        end
      end
      ST_ADDR: begin
        beat_last = (beat_cnt == 8'(ADDR_BEATS - 1));
        if (mvalid) begin
          rx_shift = 1'b1;
          if (beat_last) state_nxt = ST_LEN;
        end
      end
      ST_LEN: begin
        beat_last = (beat_cnt == 8'(LEN_BEATS - 1));
        if (mvalid) begin
          rx_shift = 1'b1;
          if (beat_last) begin
            if (mode == SMODE_WRITE) state_nxt = ST_WDATA;
            else if (SPLIT_EN != 0)  state_nxt = ST_SPLIT;
            else                     state_nxt = ST_MREAD;
          end
        end
      end
      ST_WDATA: begin
        rx_shift  = 1'b1;
        beat_last = (beat_cnt == 8'(DATA_BEATS - 1));
        if (beat_last) state_nxt = ST_MWRITE;
      end
      ST_MWRITE: begin
        smemwen   = 1'b1;
        state_nxt = (word_cnt == len) ? ST_IDLE : ST_WDATA;
      end
      ST_SPLIT: begin
        ssplit = 1'b1;
        if (split_cnt == 8'(SPLIT_LATENCY - 1)) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (split_grant) state_nxt = ST_MREAD;
      end
      ST_MREAD: begin
        smemren = 1'b1;
        if (rvalid) begin
          tx_load   = 1'b1;
          state_nxt = ST_RDATA;
        end
      end
      ST_RDATA: begin
        svalid    = 1'b1;
        srdata    = sh_dout;
        tx_shift  = 1'b1;
        beat_last = (beat_cnt == 8'(DATA_BEATS - 1));
        if (beat_last) state_nxt = (word_cnt == len) ? ST_IDLE : ST_MREAD;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      mode      <= SMODE_READ;
      beat_cnt  <= '0;
      split_cnt <= '0;
      len       <= '0;
      word_cnt  <= '0;
      addr      <= '0;
      wdata     <= '0;
    end else begin
      split_cnt <= (state == ST_SPLIT) ? split_cnt + 8'd1 : 8'd0;
      if (rx_shift || tx_shift) beat_cnt <= beat_last ? 8'd0 : beat_cnt + 8'd1;
      if (state == ST_IDLE) begin
        word_cnt <= '0;
        if (mvalid) mode <= smode;
      end
      // Fields are taken from the shifter's next value so they are ready the cycle after their last beat.
      if (state == ST_ADDR && rx_shift && beat_last) addr  <= sh_next[RX_W-1 -: ADDR_WIDTH];
      if (state == ST_LEN  && rx_shift && beat_last) len   <= sh_next[RX_W-1 -: LEN_WIDTH];
      if (state == ST_WDATA && beat_last)            wdata <= sh_next[RX_W-1 -: DATA_WIDTH];
      if (state == ST_MWRITE || (state == ST_RDATA && beat_last)) begin
        addr     <= addr + 1'b1;
        word_cnt <= word_cnt + 1'b1;
      end
    end
  end

  assign smemaddr  = addr;
  assign smemwdata = wdata;

endmodule
